// File: rtl/serial_word_packer.sv
// Framed serial-to-parallel packer: hunts for sync, packs M bits per word and
// presents each word through a one-entry valid/ready holding register.
module serial_word_packer #(
  parameter int M         = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         sync,
  output logic [M-1:0] word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         misalign,
  output logic         overflow
);

  // state   | meaning
  // HUNT    | discarding bits until the first sync-qualified bit
  // COLLECT | framed; shifting bits into the current word
  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int CW = $clog2(M + 1);

  // Framing state is held in three copies and read through a majority vote;
  // every copy reloads the voted next value, so a single upset heals in a clock.
  state_t        r_state [3];
  logic [CW-1:0] r_count [3];
  logic [M-1:0]  r_shift [3];

  state_t        w_state;
  state_t        w_state_nxt;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_nxt;
  logic [M-1:0]  w_shift;
  logic [M-1:0]  w_shift_nxt;
  logic [M-1:0]  w_shift_in;
  logic [M-1:0]  w_shift_fresh;
  logic          w_complete;
  logic          w_misalign;

  logic [M-1:0]  r_word_out;
  logic          r_word_valid;
  logic          r_misalign;
  logic          r_overflow;

  assign w_state = state_t'((r_state[0] & r_state[1]) |
                            (r_state[0] & r_state[2]) |
                            (r_state[1] & r_state[2]));
  assign w_count = (r_count[0] & r_count[1]) |
                   (r_count[0] & r_count[2]) |
                   (r_count[1] & r_count[2]);
  assign w_shift = (r_shift[0] & r_shift[1]) |
                   (r_shift[0] & r_shift[2]) |
                   (r_shift[1] & r_shift[2]);

  // Stale bits of the previous word are pushed out by the time count reaches M.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_in    = {w_shift[M-2:0], sin};
      assign w_shift_fresh = {{(M-1){1'b0}}, sin};
    end else begin : g_lsb_first
      assign w_shift_in    = {sin, w_shift[M-1:1]};
      assign w_shift_fresh = {sin, {(M-1){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        r_state[i] <= HUNT;
        r_count[i] <= '0;
        r_shift[i] <= '0;
      end else begin
        r_state[i] <= w_state_nxt;
        r_count[i] <= w_count_nxt;
        r_shift[i] <= w_shift_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    w_count_nxt = w_count;
    w_shift_nxt = w_shift;
    w_complete  = 1'b0;
    w_misalign  = 1'b0;
    case (w_state)
      HUNT: begin
        if (sin_valid && sync) begin
          w_shift_nxt = w_shift_fresh;
          w_count_nxt = CW'(1);
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (sin_valid) begin
          if (sync && (w_count != '0)) begin
            w_shift_nxt = w_shift_fresh;
            w_count_nxt = CW'(1);
            w_misalign  = 1'b1;
          end else begin
            w_shift_nxt = w_shift_in;
            if (w_count == CW'(M - 1)) begin
              w_count_nxt = '0;
              w_complete  = 1'b1;
            end else begin
              w_count_nxt = w_count + CW'(1);
            end
          end
        end
      end
    endcase
  end

  // A consumer draining the held word in the completion cycle frees the slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_misalign   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_misalign <= w_misalign;
      if (w_complete) begin
        if (!r_word_valid || word_ready) begin
          r_word_out   <= w_shift_in;
          r_word_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_word_valid && word_ready) begin
        r_word_valid <= 1'b0;
      end
    end
  end

  assign word_out   = r_word_out;
  assign word_valid = r_word_valid;
  assign misalign   = r_misalign;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_word_packer.sv
// Bench for serial_word_packer (M=4, both bit orders): directed scenarios plus
// random traffic compared cycle by cycle against a queue-based framing model.
module tb_serial_word_packer;

  localparam int M = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         sin;
  logic         sin_valid;
  logic         sync;
  logic         word_ready;

  logic [M-1:0] word_out_m, word_out_l;
  logic         valid_m, valid_l, mis_m, mis_l, ovf_m, ovf_l;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit           mdl_synced;
  bit           mdl_bits[$];
  logic [M-1:0] exp_word_m, exp_word_l;
  logic         exp_valid, exp_mis, exp_ovf;

  always #5 clock = ~clock;

  serial_word_packer #(.M(M), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .word_out(word_out_m), .word_valid(valid_m), .word_ready(word_ready),
    .misalign(mis_m), .overflow(ovf_m)
  );

  serial_word_packer #(.M(M), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .word_out(word_out_l), .word_valid(valid_l), .word_ready(word_ready),
    .misalign(mis_l), .overflow(ovf_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the specified behaviour, applied to the inputs seen at the edge.
  task automatic model_step(input logic v, input logic y, input logic b,
                            input logic r, input logic rst);
    bit done = 0;
    bit mis = 0;
    logic [M-1:0] nm = '0;
    logic [M-1:0] nl = '0;
    if (rst) begin
      mdl_synced = 0;
      mdl_bits.delete();
      exp_word_m = '0;
      exp_word_l = '0;
      exp_valid  = 1'b0;
      exp_mis    = 1'b0;
      exp_ovf    = 1'b0;
      return;
    end
    if (v) begin
      if (!mdl_synced) begin
        if (y) begin
          mdl_synced = 1;
          mdl_bits.delete();
          mdl_bits.push_back(b);
        end
      end else if (y && mdl_bits.size() != 0) begin
        mdl_bits.delete();
        mdl_bits.push_back(b);
        mis = 1;
      end else begin
        mdl_bits.push_back(b);
        if (mdl_bits.size() == M) begin
          for (int i = 0; i < M; i++) begin
            nm[M-1-i] = mdl_bits[i];
            nl[i]     = mdl_bits[i];
          end
          done = 1;
          mdl_bits.delete();
        end
      end
    end
    if (done) begin
      if (!exp_valid || r) begin
        exp_valid  = 1'b1;
        exp_word_m = nm;
        exp_word_l = nl;
      end else begin
        exp_ovf = 1'b1;
      end
    end else if (exp_valid && r) begin
      exp_valid = 1'b0;
    end
    exp_mis = mis;
  endtask

  task automatic cyc(input logic v, input logic y, input logic b,
                     input logic r, input logic rst);
    sin_valid  = v;
    sync       = y;
    sin        = b;
    word_ready = r;
    reset      = rst;
    @(posedge clock);
    model_step(v, y, b, r, rst);
    #1;
    check("word_m",  32'(word_out_m), 32'(exp_word_m));
    check("word_l",  32'(word_out_l), 32'(exp_word_l));
    check("valid_m", 32'(valid_m),    32'(exp_valid));
    check("valid_l", 32'(valid_l),    32'(exp_valid));
    check("mis_m",   32'(mis_m),      32'(exp_mis));
    check("mis_l",   32'(mis_l),      32'(exp_mis));
    check("ovf_m",   32'(ovf_m),      32'(exp_ovf));
    check("ovf_l",   32'(ovf_l),      32'(exp_ovf));
  endtask

  task automatic send(input logic y, input logic b, input logic r);
    cyc(1'b1, y, b, r, 1'b0);
  endtask

  task automatic idle(input logic r);
    cyc(1'b0, 1'b0, 1'b0, r, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    sin = 0; sin_valid = 0; sync = 0; word_ready = 0; reset = 1;
    mdl_synced = 0;
    exp_word_m = '0; exp_word_l = '0;
    exp_valid = 0; exp_mis = 0; exp_ovf = 0;

    // 1: basic word, one-cycle latency, consumed immediately
    do_reset();
    check("rst_valid", 32'(valid_m), 32'(0));
    check("rst_word",  32'(word_out_m), 32'(0));
    send(1, 1, 1); send(0, 0, 1); send(0, 1, 1);
    check("t1_early", 32'(valid_m), 32'(0));
    send(0, 1, 1);
    check("t1_word",  32'(word_out_m), 32'hB);
    check("t1_wordl", 32'(word_out_l), 32'hD);
    check("t1_valid", 32'(valid_m), 32'(1));
    idle(1);
    check("t1_drop",  32'(valid_m), 32'(0));

    // 2: bits before any sync are ignored
    do_reset();
    send(0, 1, 1); send(0, 1, 1); send(0, 1, 1);
    send(1, 0, 1); send(0, 1, 1); send(0, 1, 1); send(0, 0, 1);
    check("t2_word",  32'(word_out_m), 32'h6);
    check("t2_valid", 32'(valid_m), 32'(1));

    // 3: mid-word sync drops the partial word
    do_reset();
    send(1, 1, 1); send(0, 0, 1); send(1, 0, 1);
    check("t3_mis", 32'(mis_m), 32'(1));
    send(0, 0, 1);
    check("t3_mis_end", 32'(mis_m), 32'(0));
    send(0, 1, 1); send(0, 1, 1);
    check("t3_word", 32'(word_out_m), 32'h3);

    // 4: overflow while held, then drain
    do_reset();
    send(1, 1, 0); send(0, 0, 0); send(0, 1, 0); send(0, 0, 0);
    send(0, 0, 0); send(0, 1, 0); send(0, 0, 0); send(0, 1, 0);
    check("t4_word", 32'(word_out_m), 32'hA);
    check("t4_ovf",  32'(ovf_m), 32'(1));
    idle(1);
    check("t4_drain", 32'(valid_m), 32'(0));
    check("t4_sticky", 32'(ovf_m), 32'(1));

    // 5: drain and refill in the same cycle, with stalls and sync on a word boundary
    do_reset();
    send(1, 1, 1); send(0, 0, 1); send(0, 1, 1); send(0, 1, 0);
    send(1, 1, 0); idle(0); send(0, 1, 0); idle(0); idle(0); send(0, 0, 0);
    check("t5_hold", 32'(word_out_m), 32'hB);
    send(0, 0, 1);
    check("t5_word",  32'(word_out_m), 32'hC);
    check("t5_wordl", 32'(word_out_l), 32'h3);
    check("t5_valid", 32'(valid_m), 32'(1));
    check("t5_ovf",   32'(ovf_m), 32'(0));

    // 6: reset mid-word and while a word is held, then no packing without sync
    do_reset();
    send(1, 1, 0); send(0, 0, 0); send(0, 1, 0); send(0, 1, 0);
    send(1, 0, 0); send(0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    check("t6_valid", 32'(valid_m), 32'(0));
    check("t6_word",  32'(word_out_m), 32'(0));
    send(0, 1, 1); send(0, 0, 1); send(0, 1, 1); send(0, 1, 1); send(0, 1, 1);
    check("t6_nosync", 32'(valid_m), 32'(0));

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cyc(logic'($urandom_range(3) != 0),
          logic'($urandom_range(7) == 0),
          logic'($urandom_range(1)),
          logic'($urandom_range(1)),
          logic'($urandom_range(399) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
